sound_playback_scheduler: RTL and testbench

Sequences the stereo sample ring buffer that sits between the RX packet path and the AC97 output. It counts committed write frames and AC97 slot requests, holds playback muted until a prefill watermark is reached, and issues one read-advance pulse per AC97 slot while playing. It recovers from underrun by re-entering prefill and rejects writes when the buffer is full, keeping saturating event counters for debug.

---
 rtl/sound_playback_scheduler.sv | 124 ++++++++++++
 tb/tb_sound_playback_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_playback_scheduler.sv
// Playback sequencer for the stereo sample ring: tracks fill level, gates AC97
// slot requests into read-advance pulses, and recovers from underrun via prefill.
module sound_playback_scheduler #(
   parameter int unsigned BUF_DEPTH   = 48000,
   parameter int unsigned START_LEVEL = 4800
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        flush,
   input  logic        wr_frame,
   output logic        wr_accept,
   input  logic        slot_req,
   output logic        rd_pop,
   output logic        mute,
   output logic        play_active,
   output logic [15:0] fill_level,
   output logic [7:0]  underrun_cnt,
   output logic [7:0]  overrun_cnt,
   output logic [1:0]  state
);

   localparam int unsigned LVL_W = 16;
   localparam int unsigned CNT_W = 8;
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(BUF_DEPTH);
   localparam logic [LVL_W-1:0] START_L = LVL_W'(START_LEVEL);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PREFILL = 2'd1,
      S_PLAY    = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [LVL_W-1:0]   r_level;
   logic [LVL_W-1:0]   w_level_nxt;
   logic [CNT_W-1:0]   r_urun;
   logic [CNT_W-1:0]   w_urun_nxt;
   logic [CNT_W-1:0]   r_orun;
   logic [CNT_W-1:0]   w_orun_nxt;
   logic               r_pop;
   logic               r_mute;
   logic               r_play;
   logic               w_pop;
   logic               w_underrun;
   logic               w_wr_ok;
   logic               w_accept;

   // Full check uses the registered level, so an accepted write can never overflow
   assign w_accept  = (r_level != DEPTH_L) && !flush;
   assign wr_accept = w_accept;

   always_comb begin
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      w_urun_nxt  = r_urun;
      w_orun_nxt  = r_orun;
      w_pop       = 1'b0;
      w_underrun  = 1'b0;
      w_wr_ok     = wr_frame && w_accept;

      if ((r_state == S_PLAY) && slot_req && !flush) begin
         if (r_level != '0) w_pop      = 1'b1;
         else               w_underrun = 1'b1;
      end

      if (wr_frame && (r_level == DEPTH_L) && !flush && (r_orun != '1))
         w_orun_nxt = r_orun + CNT_W'(1);
      if (w_underrun && (r_urun != '1))
         w_urun_nxt = r_urun + CNT_W'(1);

      if (flush)                   w_level_nxt = '0;
      else if (w_wr_ok && !w_pop)  w_level_nxt = r_level + LVL_W'(1);
      else if (!w_wr_ok && w_pop)  w_level_nxt = r_level - LVL_W'(1);

      case (r_state)
         S_IDLE: begin
            if (enable) w_state_nxt = S_PREFILL;
         end
         S_PREFILL: begin
            if (!enable)                 w_state_nxt = S_IDLE;
            else if (r_level >= START_L) w_state_nxt = S_PLAY;
         end
         S_PLAY: begin
            if (!enable)        w_state_nxt = S_IDLE;
            else if (w_underrun) w_state_nxt = S_PREFILL;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Flush discards content and restarts prefill (or idles when disabled)
      if (flush) w_state_nxt = enable ? S_PREFILL : S_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_level <= '0;
         r_urun  <= '0;
         r_orun  <= '0;
         r_pop   <= 1'b0;
         r_mute  <= 1'b1;
         r_play  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_level <= w_level_nxt;
         r_urun  <= w_urun_nxt;
         r_orun  <= w_orun_nxt;
         r_pop   <= w_pop;
         r_mute  <= (w_state_nxt != S_PLAY);
         r_play  <= (w_state_nxt == S_PLAY);
      end
   end

   assign rd_pop       = r_pop;
   assign mute         = r_mute;
   assign play_active  = r_play;
   assign fill_level   = r_level;
   assign underrun_cnt = r_urun;
   assign overrun_cnt  = r_orun;
   assign state        = r_state;

endmodule

// File: tb/tb_sound_playback_scheduler.sv
// Self-checking bench for sound_playback_scheduler: directed vector table,
// corner-case sequences and randomized traffic against a behavioural model.
module tb_sound_playback_scheduler;

   localparam int unsigned DEPTH = 40;
   localparam int unsigned START = 6;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        flush;
   logic        wr_frame;
   logic        wr_accept;
   logic        slot_req;
   logic        rd_pop;
   logic        mute;
   logic        play_active;
   logic [15:0] fill_level;
   logic [7:0]  underrun_cnt;
   logic [7:0]  overrun_cnt;
   logic [1:0]  state;

   sound_playback_scheduler #(.BUF_DEPTH(DEPTH), .START_LEVEL(START)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
      .wr_frame(wr_frame), .wr_accept(wr_accept), .slot_req(slot_req),
      .rd_pop(rd_pop), .mute(mute), .play_active(play_active),
      .fill_level(fill_level), .underrun_cnt(underrun_cnt),
      .overrun_cnt(overrun_cnt), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // behavioural model: 0=idle, 1=prefill, 2=play
   int m_state, m_level, m_pop, m_urun, m_orun;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_level = 0; m_pop = 0; m_urun = 0; m_orun = 0;
   endtask

   task automatic model_step(input logic en, input logic fl, input logic wr, input logic sr);
      int nstate, nlevel;
      bit popped, starved, taken;
      popped = 0; starved = 0;
      if (fl) begin
         m_level = 0;
         m_pop   = 0;
         m_state = en ? 1 : 0;
      end else begin
         if (m_state == 2 && sr) begin
            if (m_level > 0) popped = 1;
            else             starved = 1;
         end
         taken = wr && (m_level < DEPTH);
         if (wr && !taken) m_orun = (m_orun < 255) ? m_orun + 1 : 255;
         if (starved)      m_urun = (m_urun < 255) ? m_urun + 1 : 255;
         nlevel = m_level + (taken ? 1 : 0) - (popped ? 1 : 0);
         if (!en)                                 nstate = 0;
         else if (m_state == 0)                   nstate = 1;
         else if (m_state == 1)                   nstate = (m_level >= START) ? 2 : 1;
         else                                     nstate = starved ? 1 : 2;
         m_level = nlevel;
         m_state = nstate;
         m_pop   = popped ? 1 : 0;
      end
   endtask

   task automatic compare_model();
      chk("state",        int'(state),        m_state);
      chk("fill_level",   int'(fill_level),   m_level);
      chk("rd_pop",       int'(rd_pop),       m_pop);
      chk("mute",         int'(mute),         (m_state == 2) ? 0 : 1);
      chk("play_active",  int'(play_active),  (m_state == 2) ? 1 : 0);
      chk("underrun_cnt", int'(underrun_cnt), m_urun);
      chk("overrun_cnt",  int'(overrun_cnt),  m_orun);
   endtask

   task automatic tick(input logic en, input logic fl, input logic wr, input logic sr);
      enable = en; flush = fl; wr_frame = wr; slot_req = sr;
      #1;
      chk("wr_accept", int'(wr_accept), ((m_level != DEPTH) && !fl) ? 1 : 0);
      @(posedge clk);
      model_step(en, fl, wr, sr);
      #1;
      compare_model();
   endtask

   typedef struct {
      logic en, fl, wr, sr;
      int   exp_state, exp_level, exp_pop, exp_mute;
   } vec_t;

   vec_t vecs[12];
   int   pops;
   int   guard;

   initial begin
      vecs[0]  = '{1,0,1,0, 1,1,0,1};
      vecs[1]  = '{1,0,1,1, 1,2,0,1};
      vecs[2]  = '{1,0,1,0, 1,3,0,1};
      vecs[3]  = '{1,0,1,0, 1,4,0,1};
      vecs[4]  = '{1,0,1,0, 1,5,0,1};
      vecs[5]  = '{1,0,1,0, 1,6,0,1};
      vecs[6]  = '{1,0,0,0, 2,6,0,0};
      vecs[7]  = '{1,0,0,1, 2,5,1,0};
      vecs[8]  = '{1,0,1,1, 2,5,1,0};
      vecs[9]  = '{0,0,0,1, 0,4,1,1};
      vecs[10] = '{0,0,0,1, 0,4,0,1};
      vecs[11] = '{1,1,1,0, 1,0,0,1};

      reset_n = 1'b0; enable = 0; flush = 0; wr_frame = 0; slot_req = 0;
      model_reset();
      #12;
      chk("rst_state", int'(state), 0);
      chk("rst_level", int'(fill_level), 0);
      chk("rst_mute",  int'(mute), 1);
      chk("rst_play",  int'(play_active), 0);
      chk("rst_pop",   int'(rd_pop), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         tick(vecs[i].en, vecs[i].fl, vecs[i].wr, vecs[i].sr);
         chk($sformatf("vec%0d_state", i), int'(state),      vecs[i].exp_state);
         chk($sformatf("vec%0d_level", i), int'(fill_level), vecs[i].exp_level);
         chk($sformatf("vec%0d_pop", i),   int'(rd_pop),     vecs[i].exp_pop);
         chk($sformatf("vec%0d_mute", i),  int'(mute),       vecs[i].exp_mute);
      end

      // underrun: play at level 3, four spaced slot requests
      for (int i = 0; i < 6; i++) tick(1, 0, 1, 0);
      tick(1, 0, 0, 0);
      chk("ur_play", int'(state), 2);
      for (int i = 0; i < 3; i++) tick(1, 0, 0, 1);
      chk("ur_level3", int'(fill_level), 3);
      pops = 0;
      for (int k = 0; k < 4; k++) begin
         tick(1, 0, 0, 1);
         pops += int'(rd_pop);
         for (int j = 0; j < 9; j++) begin
            tick(1, 0, 0, 0);
            pops += int'(rd_pop);
         end
      end
      chk("ur_pops",  pops, 3);
      chk("ur_level", int'(fill_level), 0);
      chk("ur_cnt",   int'(underrun_cnt), 1);
      chk("ur_state", int'(state), 1);
      chk("ur_mute",  int'(mute), 1);

      // full buffer and overrun
      for (int i = 0; i < DEPTH + 3; i++) tick(1, 0, 1, 0);
      chk("full_level",  int'(fill_level), DEPTH);
      chk("full_accept", int'(wr_accept), 0);
      chk("full_orun",   int'(overrun_cnt), 3);
      tick(1, 0, 0, 1);
      chk("full_pop_level", int'(fill_level), DEPTH - 1);
      tick(1, 0, 1, 1);
      chk("wrpop_level", int'(fill_level), DEPTH - 1);
      chk("wrpop_pop",   int'(rd_pop), 1);

      // flush coincident with write and slot request
      for (int i = 0; i < DEPTH - 1 - 20; i++) tick(1, 0, 0, 1);
      chk("fl_pre_level", int'(fill_level), 20);
      tick(1, 1, 1, 1);
      chk("fl_level", int'(fill_level), 0);
      chk("fl_pop",   int'(rd_pop), 0);
      chk("fl_orun",  int'(overrun_cnt), 3);
      chk("fl_state", int'(state), 1);

      // enable drop in play with a slot request on the same edge
      for (int i = 0; i < 10; i++) tick(1, 0, 1, 0);
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 1);
      chk("dis_pop",   int'(rd_pop), 1);
      chk("dis_state", int'(state), 0);
      chk("dis_mute",  int'(mute), 1);
      pops = 0;
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0, 1);
         pops += int'(rd_pop);
      end
      chk("dis_pops", pops, 0);
      chk("dis_level", int'(fill_level), 9);

      // underrun counter saturation
      for (int n = 0; n < 300; n++) begin
         guard = 0;
         while (m_state != 2 && guard < 100) begin tick(1, 0, 1, 0); guard++; end
         while (m_state == 2 && guard < 200) begin tick(1, 0, 0, 1); guard++; end
         if (guard >= 200) begin
            chk("sat_timeout", guard, 0);
            break;
         end
      end
      chk("sat_urun", int'(underrun_cnt), 255);

      // asynchronous reset mid-cycle
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_level", int'(fill_level), 0);
      chk("arst_mute",  int'(mute), 1);
      chk("arst_play",  int'(play_active), 0);
      chk("arst_pop",   int'(rd_pop), 0);
      chk("arst_urun",  int'(underrun_cnt), 0);
      chk("arst_orun",  int'(overrun_cnt), 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // randomized traffic, two mixes to exercise both underrun and overrun
      for (int i = 0; i < 3000; i++) begin
         logic en, fl, wr, sr;
         en = ($urandom_range(99, 0) < 94);
         fl = ($urandom_range(99, 0) < 2);
         if (i < 1500) begin
            wr = ($urandom_range(99, 0) < 35);
            sr = ($urandom_range(99, 0) < 40);
         end else begin
            wr = ($urandom_range(99, 0) < 70);
            sr = ($urandom_range(99, 0) < 25);
         end
         tick(en, fl, wr, sr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
